// File: rtl/grf_mp.sv
// rtl/grf_mp.sv - multi-port register file with dual prioritised writes, bypass and scrub engine
module grf_mp #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int NRD      = 2,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we0,
  input  logic [AW-1:0]     wa0,
  input  logic [DW-1:0]     wd0,
  input  logic              we1,
  input  logic [AW-1:0]     wa1,
  input  logic [DW-1:0]     wd1,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD*DW-1:0] rd,
  input  logic              clr_req,
  output logic              clr_busy
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SCRUB = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [AW:0]   idx_q, idx_d;
  logic [DW-1:0] mem_q [DEPTH];

  logic wr0_ok;
  logic wr1_ok;
  logic byp_en;

  // A write is live only while idle and, with a hardwired zero entry, not aimed at entry 0
  assign wr0_ok = we0 && (state_q == IDLE) && !(ZERO_REG && (wa0 == '0));
  assign wr1_ok = we1 && (state_q == IDLE) && !(ZERO_REG && (wa1 == '0));
  assign byp_en = BYPASS && !reset && (state_q == IDLE);

  assign clr_busy = (state_q == SCRUB);

  // Scrub sequencing: walk the index from 0 to the last entry, then fall back to idle
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = SCRUB;
          idx_d   = '0;
        end
      end
      SCRUB: begin
        idx_d = idx_q + (AW+1)'(1);
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Scrub state and index registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Array update: reset clears everything, scrub clears one entry, otherwise port 1 overrides port 0
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (state_q == SCRUB) begin
      mem_q[idx_q[AW-1:0]] <= '0;
    end else begin
      if (wr0_ok) begin
        mem_q[wa0] <= wd0;
      end
      if (wr1_ok) begin
        mem_q[wa1] <= wd1;
      end
    end
  end

  // Combinational read ports with optional same-cycle forwarding, port 1 data taking precedence
  always_comb begin
    rd = '0;
    for (int k = 0; k < NRD; k++) begin
      if (!(ZERO_REG && (ra[k*AW +: AW] == '0))) begin
        rd[k*DW +: DW] = mem_q[ra[k*AW +: AW]];
        if (byp_en && wr0_ok && (wa0 == ra[k*AW +: AW])) begin
          rd[k*DW +: DW] = wd0;
        end
        if (byp_en && wr1_ok && (wa1 == ra[k*AW +: AW])) begin
          rd[k*DW +: DW] = wd1;
        end
      end
    end
  end

endmodule

// File: doc/grf_mp.md
Name: grf_mp

Overview:
- Parametrised general-purpose register file for the next-generation CPU datapath.
- Generalises the single-write, two-read register file to:
  - configurable data width and depth;
  - configurable number of read ports;
  - two write ports with fixed priority;
  - optional write-to-read bypass;
  - a multi-cycle scrub engine that clears the array on request without a global reset.
- Sits between the decode stage (read) and the writeback stage(s) (write).

Parameters:
- DW, 32, data width in bits.
- AW, 5, address width; depth = 2**AW entries.
- NRD, 2, number of read ports (1..4).
- BYPASS, 1, 1 = a read of an entry being written this cycle returns the new data; 0 = returns the stored value.
- ZERO_REG, 1, 1 = entry 0 is hardwired to zero; 0 = entry 0 is an ordinary register.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- we0  input  1  write enable, port 0.
- wa0  input  AW  write address, port 0.
- wd0  input  DW  write data, port 0.
- we1  input  1  write enable, port 1 (higher priority).
- wa1  input  AW  write address, port 1.
- wd1  input  DW  write data, port 1.
- ra  input  NRD*AW  packed read addresses; port k = ra[k*AW +: AW].
- rd  output  NRD*DW  packed read data; port k = rd[k*DW +: DW].
- clr_req  input  1  single-cycle pulse; starts a scrub.
- clr_busy  output  1  high while a scrub is in progress.

Behaviour:
- Reset (synchronous, active-high):
  - All entries cleared to 0 at the clock edge.
  - Scrub FSM returns to IDLE; clr_busy = 0.
  - clr_req and writes in the reset cycle are ignored.
  - After reset, every rd port reads 0.
- Writes:
  - Committed at the rising clk edge when weN = 1 and the FSM is IDLE.
  - With ZERO_REG = 1, writes to address 0 are discarded.
- Simultaneous writes:
  - we0 = we1 = 1 with wa0 == wa1: port 1's data is stored; port 0 is dropped.
  - Different addresses: both commit in the same cycle.
- Reads are combinational, zero latency; each port is independent.
- Read of address 0 with ZERO_REG = 1 returns 0 always, regardless of bypass.
- Bypass (BYPASS = 1; FSM IDLE; no reset this cycle):
  - If ra[k] matches an enabled, non-discarded write address in the same cycle, rd[k] returns that write data.
  - If both write ports match, port 1's data is returned.
  - BYPASS = 0: rd[k] returns the pre-edge stored value; new data is visible the next cycle.
- Scrub FSM:
  - States: IDLE, SCRUB.
  - IDLE → SCRUB on clr_req = 1: index counter := 0, clr_busy := 1 from the next cycle.
  - SCRUB: each cycle clears entry[index] to 0 and increments index.
  - SCRUB → IDLE on the cycle entry 2**AW−1 is cleared; clr_busy := 0 the next cycle.
  - Total: exactly 2**AW busy cycles.
- During SCRUB:
  - we0/we1 are ignored and their data dropped; no bypass.
  - Reads return current array contents, so partially scrubbed values are visible.
  - Further clr_req pulses are ignored; the scrub does not restart.
- clr_req in the same cycle as writes while IDLE: the writes commit, then the scrub begins the next cycle and clears them.
- Reset mid-scrub: the array is fully cleared immediately; FSM → IDLE; clr_busy = 0 on the next cycle.
- Index counter: AW+1 bits, so the terminal entry needs no wrap special case.
- No X propagation: out-of-range read ports do not exist, since all addresses in the AW range are valid.

Test Plan:
- Reset, then read all 32 addresses on both ports → all rd = 0x00000000; clr_busy = 0.
- we0 = 1, wa0 = 3, wd0 = 0x12345678; ra port 0 = 3 in the same cycle:
  - BYPASS = 1 → rd0 = 0x12345678 in the same cycle.
  - BYPASS = 0 → rd0 = 0 that cycle, 0x12345678 the next.
- Both ports write address 7: wd0 = 0xAAAA0000, wd1 = 0x0000BBBB → stored and bypassed value = 0x0000BBBB. we1 to address 0 with 0xFFFFFFFF → read of address 0 = 0.
- Fill entries 1..31 with value = index, then pulse clr_req:
  - clr_busy is high for exactly 32 cycles.
  - A write to address 5 during the scrub is dropped.
  - Afterwards all entries = 0.
- Start a scrub, assert reset at busy cycle 10 → the next cycle clr_busy = 0 and all entries = 0; a new write then commits normally.
- NRD = 4 instance: four distinct addresses read concurrently → each rd slice matches its own entry, with no cross-port aliasing.
